// File: rtl/exc_sched.sv
// Exception/interrupt scheduler between the M stage and CP0: arbitrates requests, latches EPC/BD/code,
// and sequences flush and redirect. Optional macro EXC_DELAY_SLOT_EN enables delay-slot EPC adjustment.
module exc_sched #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_m,
    input  logic        eret_m,
    input  logic [5:0]  hwint,
    input  logic [5:0]  sr_im,
    input  logic        sr_ie,
    input  logic        sr_exl,
    input  logic [31:0] cp0_epc,
    output logic        exl_set,
    output logic        exl_clr,
    output logic [4:0]  exc_code_o,
    output logic [31:0] epc_o,
    output logic        bd_o,
    output logic [5:0]  hwint_pend,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {IDLE, EXC, FLUSH, REDIR, RET} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             exl_set_d, exl_clr_d, flush_d, redirect_d, bd_d;
    logic [4:0]       exc_code_d;
    logic [31:0]      epc_d, redirect_pc_d;
    logic             int_req, exc_req, eret_req;
    logic [31:0]      pc_aligned, epc_calc;
    logic             bd_calc;
    logic [1:0]       pc_lsb_unused;

    assign pc_lsb_unused = pc_m[1:0];
    assign pc_aligned    = {pc_m[31:2], 2'b00};

`ifdef EXC_DELAY_SLOT_EN
    assign epc_calc = bd_m ? (pc_aligned - 32'd4) : pc_aligned;
    assign bd_calc  = bd_m;
`else
    logic bd_m_unused;
    assign bd_m_unused = bd_m;
    assign epc_calc    = pc_aligned;
    assign bd_calc     = 1'b0;
`endif

    assign int_req  = (|(hwint_pend & sr_im)) & sr_ie & ~sr_exl & m_valid;
    assign exc_req  = (exc_code_m != 5'd0) & m_valid;
    assign eret_req = eret_m & m_valid;

    // Next state plus next values of the registered outputs, so each strobe lines up with its state.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        exl_set_d     = 1'b0;
        exl_clr_d     = 1'b0;
        flush_d       = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc;
        exc_code_d    = exc_code_o;
        epc_d         = epc_o;
        bd_d          = bd_o;
        case (state)
            IDLE: begin
                if (int_req || exc_req) begin
                    state_d    = EXC;
                    exc_code_d = int_req ? 5'd0 : exc_code_m;
                    epc_d      = epc_calc;
                    bd_d       = bd_calc;
                    exl_set_d  = 1'b1;
                    flush_d    = 1'b1;
                end else if (eret_req) begin
                    state_d       = RET;
                    redirect_pc_d = cp0_epc;
                    exl_clr_d     = 1'b1;
                    flush_d       = 1'b1;
                    redirect_d    = 1'b1;
                end
            end
            EXC: begin
                if (FLUSH_CYCLES <= 1) begin
                    state_d       = REDIR;
                    cnt_d         = '0;
                    redirect_d    = 1'b1;
                    redirect_pc_d = HANDLER_ADDR;
                end else begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    flush_d = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt <= CNT_W'(1)) begin
                    state_d       = REDIR;
                    cnt_d         = '0;
                    redirect_d    = 1'b1;
                    redirect_pc_d = HANDLER_ADDR;
                end else begin
                    cnt_d   = cnt - CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            REDIR:   state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and all outputs registered; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            exl_set     <= 1'b0;
            exl_clr     <= 1'b0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            exc_code_o  <= '0;
            epc_o       <= '0;
            bd_o        <= 1'b0;
            hwint_pend  <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            exl_set     <= exl_set_d;
            exl_clr     <= exl_clr_d;
            flush       <= flush_d;
            redirect    <= redirect_d;
            redirect_pc <= redirect_pc_d;
            exc_code_o  <= exc_code_d;
            epc_o       <= epc_d;
            bd_o        <= bd_d;
            hwint_pend  <= hwint;
            busy        <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched: vector table for single acceptances plus hand sequences for timing,
// masking, ERET blocking and mid-sequence reset. Expectations follow EXC_DELAY_SLOT_EN when defined.
module tb_exc_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, bd_m, eret_m, sr_ie, sr_exl;
    logic [31:0] pc_m, cp0_epc;
    logic [4:0]  exc_code_m;
    logic [5:0]  hwint, sr_im;
    logic        exl_set, exl_clr, bd_o, flush, redirect, busy;
    logic [4:0]  exc_code_o;
    logic [31:0] epc_o, redirect_pc;
    logic [5:0]  hwint_pend;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef EXC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    exc_sched dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .pc_m(pc_m), .bd_m(bd_m),
        .exc_code_m(exc_code_m), .eret_m(eret_m), .hwint(hwint), .sr_im(sr_im),
        .sr_ie(sr_ie), .sr_exl(sr_exl), .cp0_epc(cp0_epc), .exl_set(exl_set),
        .exl_clr(exl_clr), .exc_code_o(exc_code_o), .epc_o(epc_o), .bd_o(bd_o),
        .hwint_pend(hwint_pend), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  hw, im;
        logic        ie, exl, mv, er, bd;
        logic [4:0]  code;
        logic [31:0] pc, cep;
        logic        e_set, e_clr;
        logic [4:0]  e_code;
        logic [31:0] e_epc;
        logic        e_bd;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [5:0] hw, input logic [5:0] im, input logic ie,
                                input logic exl, input logic mv, input logic er, input logic bd,
                                input logic [4:0] code, input logic [31:0] pc, input logic [31:0] cep,
                                input logic es, input logic ec, input logic [4:0] ecode,
                                input logic [31:0] eepc, input logic ebd, input logic [31:0] erpc);
        vec_t v;
        v.hw = hw; v.im = im; v.ie = ie; v.exl = exl; v.mv = mv; v.er = er; v.bd = bd;
        v.code = code; v.pc = pc; v.cep = cep; v.e_set = es; v.e_clr = ec;
        v.e_code = ecode; v.e_epc = eepc; v.e_bd = ebd; v.e_rpc = erpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid = 1'b0; bd_m = 1'b0; eret_m = 1'b0; sr_ie = 1'b0; sr_exl = 1'b0;
        pc_m = 32'h0; cp0_epc = 32'h0; exc_code_m = 5'd0; hwint = 6'd0; sr_im = 6'd0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && busy; k++) tick();
        chk({name, " drain"}, 32'(busy), 32'd0);
    endtask

    task automatic do_exc(input logic [4:0] code, input logic [31:0] pc);
        exc_code_m = code; pc_m = pc; m_valid = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(6'h00, 6'h00, 0, 0, 1, 0, 0, 5'd12, 32'h3008, 32'h0,    1, 0, 5'd12, 32'h3008, 0, 32'h0);
        vecs[1]  = mk(6'h04, 6'h04, 1, 0, 1, 0, 0, 5'd4,  32'h3100, 32'h0,    1, 0, 5'd0,  32'h3100, 0, 32'h0);
        vecs[2]  = mk(6'h04, 6'h04, 1, 1, 1, 0, 0, 5'd0,  32'h3200, 32'h0,    0, 0, 5'd0,  32'h0,    0, 32'h0);
        vecs[3]  = mk(6'h04, 6'h04, 1, 0, 0, 0, 0, 5'd5,  32'h3204, 32'h0,    0, 0, 5'd0,  32'h0,    0, 32'h0);
        vecs[4]  = mk(6'h04, 6'h04, 0, 0, 1, 0, 0, 5'd0,  32'h3208, 32'h0,    0, 0, 5'd0,  32'h0,    0, 32'h0);
        vecs[5]  = mk(6'h04, 6'h02, 1, 0, 1, 0, 0, 5'd0,  32'h320c, 32'h0,    0, 0, 5'd0,  32'h0,    0, 32'h0);
        vecs[6]  = mk(6'h00, 6'h00, 0, 0, 1, 0, 0, 5'd4,  32'h3013, 32'h0,    1, 0, 5'd4,  32'h3010, 0, 32'h0);
        vecs[7]  = mk(6'h00, 6'h00, 0, 0, 1, 0, 1, 5'd10, 32'h3024, 32'h0,    1, 0, 5'd10,
                      DS ? 32'h3020 : 32'h3024, DS, 32'h0);
        vecs[8]  = mk(6'h00, 6'h00, 0, 0, 1, 1, 0, 5'd0,  32'h3300, 32'h3010, 0, 1, 5'd0,  32'h0,    0, 32'h3010);
        vecs[9]  = mk(6'h00, 6'h00, 0, 0, 1, 1, 0, 5'd13, 32'h3400, 32'h5000, 1, 0, 5'd13, 32'h3400, 0, 32'h0);
        vecs[10] = mk(6'h01, 6'h01, 1, 0, 1, 0, 1, 5'd0,  32'h0,    32'h0,    1, 0, 5'd0,
                      DS ? 32'hFFFF_FFFC : 32'h0, DS, 32'h0);
        vecs[11] = mk(6'h00, 6'h00, 0, 0, 0, 1, 0, 5'd0,  32'h3500, 32'h6000, 0, 0, 5'd0,  32'h0,    0, 32'h0);

        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        chk("rst exl_set", 32'(exl_set), 32'd0);
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst redirect_pc", redirect_pc, 32'd0);
        chk("rst epc_o", epc_o, 32'd0);
        reset = 1'b1;
        tick();

        // Overflow exception: full cycle-by-cycle timing.
        do_exc(5'd12, 32'h3008);
        chk("ovf T+1 exl_set", 32'(exl_set), 32'd1);
        chk("ovf T+1 flush", 32'(flush), 32'd1);
        chk("ovf T+1 redirect", 32'(redirect), 32'd0);
        chk("ovf T+1 code", 32'(exc_code_o), 32'd12);
        chk("ovf T+1 epc", epc_o, 32'h3008);
        tick();
        chk("ovf T+2 flush", 32'(flush), 32'd1);
        chk("ovf T+2 exl_set", 32'(exl_set), 32'd0);
        chk("ovf T+2 redirect", 32'(redirect), 32'd0);
        tick();
        chk("ovf T+3 redirect", 32'(redirect), 32'd1);
        chk("ovf T+3 redirect_pc", redirect_pc, 32'h4180);
        chk("ovf T+3 flush", 32'(flush), 32'd0);
        chk("ovf T+3 busy", 32'(busy), 32'd1);
        tick();
        chk("ovf T+4 busy", 32'(busy), 32'd0);
        chk("ovf T+4 redirect", 32'(redirect), 32'd0);
        chk("ovf T+4 code held", 32'(exc_code_o), 32'd12);

        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            hwint = vecs[i].hw;
            tick();
            hwint = vecs[i].hw; sr_im = vecs[i].im; sr_ie = vecs[i].ie; sr_exl = vecs[i].exl;
            m_valid = vecs[i].mv; eret_m = vecs[i].er; bd_m = vecs[i].bd;
            exc_code_m = vecs[i].code; pc_m = vecs[i].pc; cp0_epc = vecs[i].cep;
            tick();
            idle_inputs();
            chk($sformatf("vec%0d exl_set", i), 32'(exl_set), 32'(vecs[i].e_set));
            chk($sformatf("vec%0d exl_clr", i), 32'(exl_clr), 32'(vecs[i].e_clr));
            chk($sformatf("vec%0d redirect", i), 32'(redirect), 32'(vecs[i].e_clr));
            chk($sformatf("vec%0d flush", i), 32'(flush), 32'(vecs[i].e_set | vecs[i].e_clr));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_set | vecs[i].e_clr));
            if (vecs[i].e_set) begin
                chk($sformatf("vec%0d code", i), 32'(exc_code_o), 32'(vecs[i].e_code));
                chk($sformatf("vec%0d epc", i), epc_o, vecs[i].e_epc);
                chk($sformatf("vec%0d bd", i), 32'(bd_o), 32'(vecs[i].e_bd));
            end
            if (vecs[i].e_clr) chk($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            drain($sformatf("vec%0d", i));
        end

        // Interrupt held off by EXL, accepted in the cycle EXL drops.
        idle_inputs();
        hwint = 6'h01; sr_im = 6'h01; sr_ie = 1'b1; sr_exl = 1'b1; m_valid = 1'b1; pc_m = 32'h3600;
        tick(); tick(); tick();
        chk("exl mask exl_set", 32'(exl_set), 32'd0);
        chk("exl mask busy", 32'(busy), 32'd0);
        sr_exl = 1'b0;
        tick();
        idle_inputs();
        chk("exl drop exl_set", 32'(exl_set), 32'd1);
        chk("exl drop code", 32'(exc_code_o), 32'd0);
        chk("exl drop epc", epc_o, 32'h3600);
        drain("exl drop");

        // ERET, then an exception raised during the RET cycle must be ignored.
        cp0_epc = 32'h3010; eret_m = 1'b1; m_valid = 1'b1; pc_m = 32'h3700;
        tick();
        idle_inputs();
        chk("eret exl_clr", 32'(exl_clr), 32'd1);
        chk("eret redirect", 32'(redirect), 32'd1);
        chk("eret flush", 32'(flush), 32'd1);
        chk("eret redirect_pc", redirect_pc, 32'h3010);
        exc_code_m = 5'd7; m_valid = 1'b1; pc_m = 32'h3704;
        tick();
        idle_inputs();
        chk("eret blk exl_set", 32'(exl_set), 32'd0);
        chk("eret blk busy", 32'(busy), 32'd0);
        chk("eret blk redirect", 32'(redirect), 32'd0);
        chk("eret blk code held", 32'(exc_code_o), 32'd0);

        // Reset asserted in FLUSH, then normal acceptance after release.
        hwint = 6'h3f;
        do_exc(5'd9, 32'h3040);
        hwint = 6'h3f;
        tick();
        chk("pre-rst flush", 32'(flush), 32'd1);
        chk("pre-rst hwint_pend", 32'(hwint_pend), 32'h3f);
        reset = 1'b0;
        #1;
        chk("midrst flush", 32'(flush), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst epc_o", epc_o, 32'd0);
        chk("midrst code", 32'(exc_code_o), 32'd0);
        chk("midrst redirect_pc", redirect_pc, 32'd0);
        chk("midrst hwint_pend", 32'(hwint_pend), 32'd0);
        hwint = 6'h00;
        tick();
        reset = 1'b1;
        tick();
        chk("post-rst busy", 32'(busy), 32'd0);
        do_exc(5'd3, 32'h3050);
        chk("post-rst exl_set", 32'(exl_set), 32'd1);
        chk("post-rst code", 32'(exc_code_o), 32'd3);
        chk("post-rst epc", epc_o, 32'h3050);
        tick(); tick();
        chk("post-rst redirect", 32'(redirect), 32'd1);
        chk("post-rst redirect_pc", redirect_pc, 32'h4180);
        drain("post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
